// File: rtl/load_store_unit_if.sv
// Core-side request/response channel and data-RAM bus channel of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_err, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_err, rsp_rdata);
endinterface

interface dmem_if;
  logic        mem_r;
  logic [3:0]  mem_w;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_r, mem_w, mem_addr, mem_wdata, input  mem_rdata);
  modport slave  (input  mem_r, mem_w, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/load_store_unit.sv
// Data-memory bus initiator: one load/store at a time, splits word-crossing accesses in two.
//
// state | meaning
// IDLE  | ready for a core request
// ACC0  | bus access to the first word (base)
// ACC1  | bus access to the second word (base+4) of a split access
// DONE  | response pulse with extended load data
// ERR   | response pulse flagging an illegal width code
module load_store_unit (
  input  logic            clk,
  input  logic            rst,
  load_store_unit_if.slave core,
  dmem_if.master          mem
);

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_DONE, S_ERR} state_t;

  state_t      state, nxt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] base_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q, hi_q;

  logic        accept, illegal_in, split;
  logic [3:0]  mask4;
  logic [7:0]  mask8;
  logic [63:0] d64;
  logic [31:0] r32, ld_ext;

  logic        req_ready_c, rsp_valid_c, rsp_err_c, mem_r_c;
  logic [31:0] rsp_rdata_c, mem_addr_c, mem_wdata_c;
  logic [3:0]  mem_w_c;

  assign accept     = (state == S_IDLE) && core.req_valid;
  assign illegal_in = (core.req_funct3 == 3'b011) || (core.req_funct3[2:1] == 2'b11) ||
                      (core.req_we && core.req_funct3[2]);

  always_comb begin
    case (f3_q[1:0])
      2'b00:   mask4 = 4'b0001;
      2'b01:   mask4 = 4'b0011;
      default: mask4 = 4'b1111;
    endcase
  end

  assign mask8 = {4'b0000, mask4} << off_q;
  assign split = |mask8[7:4];
  assign d64   = {32'b0, wdata_q} << {off_q, 3'b000};

  // Window of {hi, lo} starting at the byte offset; upper bytes unused for narrow loads.
  always_comb begin
    case (off_q)
      2'd0:    r32 = lo_q;
      2'd1:    r32 = {hi_q[7:0],  lo_q[31:8]};
      2'd2:    r32 = {hi_q[15:0], lo_q[31:16]};
      default: r32 = {hi_q[23:0], lo_q[31:24]};
    endcase
  end

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{r32[7]}},  r32[7:0]};
      3'b001:  ld_ext = {{16{r32[15]}}, r32[15:0]};
      3'b100:  ld_ext = {24'b0, r32[7:0]};
      3'b101:  ld_ext = {16'b0, r32[15:0]};
      default: ld_ext = r32;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (core.req_valid) nxt = illegal_in ? S_ERR : S_ACC0;
      S_ACC0:  nxt = split ? S_ACC1 : S_DONE;
      S_ACC1:  nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      base_q  <= 32'b0;
      wdata_q <= 32'b0;
      lo_q    <= 32'b0;
      hi_q    <= 32'b0;
    end else begin
      if (accept) begin
        we_q    <= core.req_we;
        f3_q    <= core.req_funct3;
        off_q   <= core.req_addr[1:0];
        base_q  <= {core.req_addr[31:2], 2'b00};
        wdata_q <= core.req_wdata;
      end
      if (state == S_ACC0) lo_q <= mem.mem_rdata;
      if (state == S_ACC1) hi_q <= mem.mem_rdata;
    end
  end

  // Reset gates every output so an aborted store commits nothing at the falling edge.
  always_comb begin
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    rsp_err_c   = 1'b0;
    rsp_rdata_c = 32'b0;
    mem_r_c     = 1'b0;
    mem_w_c     = 4'b0;
    mem_addr_c  = 32'b0;
    mem_wdata_c = 32'b0;
    case (state)
      S_IDLE: req_ready_c = 1'b1;
      S_ACC0: begin
        mem_addr_c = base_q;
        if (we_q) begin
          mem_w_c     = mask8[3:0];
          mem_wdata_c = d64[31:0];
        end else begin
          mem_r_c = 1'b1;
        end
      end
      S_ACC1: begin
        mem_addr_c = base_q + 32'd4;
        if (we_q) begin
          mem_w_c     = mask8[7:4];
          mem_wdata_c = d64[63:32];
        end else begin
          mem_r_c = 1'b1;
        end
      end
      S_DONE: begin
        rsp_valid_c = 1'b1;
        rsp_rdata_c = we_q ? 32'b0 : ld_ext;
      end
      S_ERR: begin
        rsp_valid_c = 1'b1;
        rsp_err_c   = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      req_ready_c = 1'b0;
      rsp_valid_c = 1'b0;
      rsp_err_c   = 1'b0;
      rsp_rdata_c = 32'b0;
      mem_r_c     = 1'b0;
      mem_w_c     = 4'b0;
      mem_addr_c  = 32'b0;
      mem_wdata_c = 32'b0;
    end
  end

  assign core.req_ready = req_ready_c;
  assign core.rsp_valid = rsp_valid_c;
  assign core.rsp_err   = rsp_err_c;
  assign core.rsp_rdata = rsp_rdata_c;
  assign mem.mem_r      = mem_r_c;
  assign mem.mem_w      = mem_w_c;
  assign mem.mem_addr   = mem_addr_c;
  assign mem.mem_wdata  = mem_wdata_c;

endmodule
